// File: rtl/demux1to4_reg.sv
`default_nettype none
// ============================================================================
// Module   : demux1to4_reg
// Function : Registered 1-to-4 demultiplexer; each lane is a one-entry output
//            register with its own valid/ready handshake.
//            Optional per-lane drain counters: define DEMUX1TO4_COUNT_EN.
// Revision : 1.0  initial release
// ============================================================================
module demux1to4_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             s1,
    input  logic             s0,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic [3:0]       y_valid,
    input  logic [3:0]       y_ready
`ifdef DEMUX1TO4_COUNT_EN
    ,
    output logic [31:0]      lane_count
`endif
);

    localparam logic [7:0] c_count_max = 8'hFF;

    logic [1:0]       w_sel;
    logic             w_accept;
    logic [3:0]       w_load;
    logic [3:0]       w_drain;
    logic [3:0]       r_valid;
    logic [WIDTH-1:0] r_data [4];

    assign w_sel = {s1, s0};

    // Decoded with a default so an unknown select cannot leak onto in_ready.
    always_comb begin
        in_ready = 1'b0;
        case (w_sel)
            2'b00:   in_ready = ~r_valid[0] | y_ready[0];
            2'b01:   in_ready = ~r_valid[1] | y_ready[1];
            2'b10:   in_ready = ~r_valid[2] | y_ready[2];
            2'b11:   in_ready = ~r_valid[3] | y_ready[3];
            default: in_ready = 1'b0;
        endcase
    end

    assign w_accept = in_valid & in_ready;

    generate
        for (genvar i = 0; i < 4; i++) begin : g_lane
            localparam logic [1:0] c_lane = 2'(i);

            assign w_load[i]  = w_accept & (w_sel == c_lane);
            assign w_drain[i] = r_valid[i] & y_ready[i];

            // A load in the same cycle as a drain wins, keeping the lane valid.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_data[i]  <= '0;
                    r_valid[i] <= 1'b0;
                end else if (w_load[i]) begin
                    r_data[i]  <= din;
                    r_valid[i] <= 1'b1;
                end else if (w_drain[i]) begin
                    r_valid[i] <= 1'b0;
                end
            end
        end
    endgenerate

    assign y0      = r_data[0];
    assign y1      = r_data[1];
    assign y2      = r_data[2];
    assign y3      = r_data[3];
    assign y_valid = r_valid;

`ifdef DEMUX1TO4_COUNT_EN
    generate
        for (genvar i = 0; i < 4; i++) begin : g_count
            logic [7:0] r_count;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_count <= 8'h00;
                end else if (w_drain[i] && (r_count != c_count_max)) begin
                    r_count <= r_count + 8'd1;
                end
            end

            assign lane_count[8*i +: 8] = r_count;
        end
    endgenerate
`else
    // Counters absent: c_count_max is unused in this build.
    logic w_unused_count;
    assign w_unused_count = &c_count_max;
`endif

endmodule
`default_nettype wire

// File: doc/demux1to4_reg.md
Name: demux1to4_reg

Overview:
- Registered 1-to-4 demultiplexer; the inverse of the lab 4-to-1 mux.
- Steers one WIDTH-bit input word to one of four output lanes, chosen by {s1,s0}.
- Each lane holds its word in a one-entry output register with its own valid/ready handshake, so a stalled lane never blocks the others.
- Sits between a single producer and four independent consumers.

Parameters:
- WIDTH, 8, data width of the input word and of each lane.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- din  input  WIDTH  input data word
- in_valid  input  1  din/s1/s0 valid this cycle
- in_ready  output  1  block can accept din this cycle (combinational)
- s1  input  1  select MSB
- s0  input  1  select LSB; lane index = {s1,s0}
- y0  output  WIDTH  lane 0 data
- y1  output  WIDTH  lane 1 data
- y2  output  WIDTH  lane 2 data
- y3  output  WIDTH  lane 3 data
- y_valid  output  4  per-lane valid; bit i qualifies yi
- y_ready  input  4  per-lane consumer ready; bit i for lane i

Behaviour:
- Reset (synchronous, active-high):
  - On a clk edge with reset=1: y0..y3 <= 0, y_valid <= 4'b0000.
  - Buffered words are dropped, not delivered.
  - Reset dominates every other event in the same cycle.
- Select:
  - sel = {s1,s0}; 00 -> lane 0, 01 -> lane 1, 10 -> lane 2, 11 -> lane 3.
  - s1/s0 are only meaningful when in_valid=1.
  - When in_valid=0, s1, s0 and din are don't-care and have no effect, including X.
- in_ready = !y_valid[sel] | y_ready[sel].
  - Combinational in sel, y_valid and y_ready only; it must not depend on din.
- Accept:
  - A transfer is accepted when in_valid & in_ready.
  - On the next edge: y[sel] <= din and y_valid[sel] <= 1.
  - Latency is 1 cycle from accept to y_valid.
- Lane drain:
  - Lane i completes when y_valid[i] & y_ready[i].
  - If lane i is not reloaded in the same cycle, y_valid[i] <= 0 and yi holds its last value.
- Simultaneous drain and load on the same lane:
  - Permitted. Lane i is reloaded with the new din and y_valid[i] stays 1.
  - This gives full throughput of 1 word/cycle into one lane while its consumer is always ready.
- Non-selected lanes:
  - State is unaffected by an accept on another lane.
  - They drain independently in the same cycle.
- Full lane:
  - If y_valid[sel]=1 and y_ready[sel]=0, then in_ready=0.
  - The producer must hold din, s1, s0 and in_valid stable until accepted.
  - Lane data is not overwritten.
- Output stability:
  - While y_valid[i]=1 and y_ready[i]=0, yi is held constant.
- y_ready[i] while y_valid[i]=0 has no effect.

Optional Feature:
- Macro: DEMUX1TO4_COUNT_EN
- Defined:
  - Adds output port lane_count, 32 bits: four 8-bit fields, lane i at bits [8i+7:8i].
  - Each field counts completed drains (y_valid[i] & y_ready[i]) on lane i.
  - The counter saturates at 8'hFF and does not wrap.
  - Reset clears all counters to 0.
- Not defined:
  - lane_count port and counter logic are absent.
  - All other behaviour is identical.

Test Plan:
- Reset with every lane full:
  - Load 8'hA5 into all 4 lanes with y_ready=0, then assert reset one cycle.
  - Required: y_valid=0000 and y0..y3=0 after the edge.
- Select sweep (mux check inverted):
  - y_ready=1111; drive din=8'h01, 8'h00, 8'h01, 8'h01 with {s1,s0}=00, 01, 10, 11 on consecutive cycles.
  - Required: each word appears on lanes 0..3 exactly one cycle later, with a single-hot y_valid each cycle.
- Backpressure:
  - Lane 2 full with 8'h3C and y_ready[2]=0; offer 8'hC3 to sel=10.
  - Required: in_ready=0 and y2 stays 8'h3C.
  - Raise y_ready[2] -> in_ready=1 and 8'hC3 is accepted; y2=8'hC3 the next cycle, y_valid[2]=1.
- Throughput and lane isolation:
  - Sel=11 with y_ready[3]=1 held; stream 8'h10..8'h17 back-to-back.
  - Required: in_ready stays 1 and y3 shows 8'h10..8'h17 on 8 consecutive cycles.
  - Meanwhile lane 0 holds 8'hEE with y_ready[0]=0, and lane 0 is unchanged throughout.
- Don't-care input:
  - in_valid=0 with din=X and s1/s0=X for 3 cycles.
  - Required: y_valid and y0..y3 are unchanged and no X appears on in_ready.
- Counter (DEMUX1TO4_COUNT_EN):
  - Drain 300 words on lane 1 and 5 words on lane 0.
  - Required: lane_count[15:8]=8'hFF and lane_count[7:0]=8'h05.
